// File: rtl/mem_stage.sv
// mem_stage: data memory and hardware stack for the memory pipeline stage.
// Handles loads, stores, single-word push/pop, two-word call/ret and the
// three-word rti restore of PC and condition flags.
// Ports:
//   clk, rst                      clock, async active-high reset
//   mem_read, mem_write           load / store at addr
//   push, pop                     single-word stack push / pop
//   call, ret, rti                multi-cycle stack operations
//   addr, write_data, ret_pc      address, store/push data, PC to save
//   read_data                     registered load/pop result
//   conditions_from_memory_pop    registered flags restored by rti
//   flag_regsel, pc_load          one-cycle pulses after rti / ret completion
//   pc_out                        registered PC restored by ret/rti
//   stall                         combinational hold request to upstream
//   sp                            current stack pointer
module mem_stage #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              call,
  input  logic              ret,
  input  logic              rti,
  input  logic [15:0]       addr,
  input  logic [15:0]       write_data,
  input  logic [31:0]       ret_pc,
  output logic [15:0]       read_data,
  output logic [2:0]        conditions_from_memory_pop,
  output logic              flag_regsel,
  output logic [31:0]       pc_out,
  output logic              pc_load,
  output logic              stall,
  output logic [ADDR_W-1:0] sp
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    CALL_LO,
    RET_HI,
    RTI_HI,
    RTI_FL
  } state_t;

  state_t state, next_state;

  logic [15:0] mem [DEPTH];

  logic [ADDR_W-1:0] sp_inc, sp_dec, sp_next, mem_waddr, mem_addr;
  logic [15:0]       mem_wdata, pop_word, ld_word;
  logic              mem_we, rd_we, rd_sel_load, pcl_we, pch_we, fl_we;
  logic              pc_load_next, flag_regsel_next;

  // Upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[15:ADDR_W];

  assign mem_addr = addr[ADDR_W-1:0];
  assign sp_inc   = sp + ADDR_W'(1);
  assign sp_dec   = sp - ADDR_W'(1);
  assign pop_word = mem[sp_inc];
  assign ld_word  = mem[mem_addr];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, request arbitration and datapath controls.
  always_comb begin
    next_state       = state;
    sp_next          = sp;
    mem_we           = 1'b0;
    mem_waddr        = sp;
    mem_wdata        = write_data;
    rd_we            = 1'b0;
    rd_sel_load      = 1'b0;
    pcl_we           = 1'b0;
    pch_we           = 1'b0;
    fl_we            = 1'b0;
    pc_load_next     = 1'b0;
    flag_regsel_next = 1'b0;
    stall            = 1'b0;
    case (state)
      IDLE: begin
        if (rti) begin
          sp_next    = sp_inc;
          pcl_we     = 1'b1;
          stall      = 1'b1;
          next_state = RTI_HI;
        end else if (ret) begin
          sp_next    = sp_inc;
          pcl_we     = 1'b1;
          stall      = 1'b1;
          next_state = RET_HI;
        end else if (call) begin
          mem_we     = 1'b1;
          mem_wdata  = ret_pc[31:16];
          sp_next    = sp_dec;
          stall      = 1'b1;
          next_state = CALL_LO;
        end else if (pop) begin
          sp_next = sp_inc;
          rd_we   = 1'b1;
        end else if (push) begin
          mem_we  = 1'b1;
          sp_next = sp_dec;
        end else if (mem_write) begin
          mem_we    = 1'b1;
          mem_waddr = mem_addr;
        end else if (mem_read) begin
          rd_we       = 1'b1;
          rd_sel_load = 1'b1;
        end
      end
      CALL_LO: begin
        mem_we     = 1'b1;
        mem_wdata  = ret_pc[15:0];
        sp_next    = sp_dec;
        next_state = IDLE;
      end
      RET_HI: begin
        sp_next      = sp_inc;
        pch_we       = 1'b1;
        pc_load_next = 1'b1;
        next_state   = IDLE;
      end
      RTI_HI: begin
        sp_next    = sp_inc;
        pch_we     = 1'b1;
        stall      = 1'b1;
        next_state = RTI_FL;
      end
      RTI_FL: begin
        sp_next          = sp_inc;
        fl_we            = 1'b1;
        pc_load_next     = 1'b1;
        flag_regsel_next = 1'b1;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered outputs and stack pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp                         <= '1;
      read_data                  <= '0;
      pc_out                     <= '0;
      conditions_from_memory_pop <= '0;
      pc_load                    <= 1'b0;
      flag_regsel                <= 1'b0;
    end else begin
      sp          <= sp_next;
      pc_load     <= pc_load_next;
      flag_regsel <= flag_regsel_next;
      if (rd_we)  read_data <= rd_sel_load ? ld_word : pop_word;
      if (pcl_we) pc_out[15:0] <= pop_word;
      if (pch_we) pc_out[31:16] <= pop_word;
      if (fl_we)  conditions_from_memory_pop <= pop_word[2:0];
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 11, data-memory/stack address width (2^ADDR_W words of 16 bits).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_read  input  1  load request, address addr.
REQ-005 mem_write  input  1  store request, write_data to addr.
REQ-006 push / pop  input  1 each  single-word stack push of write_data / pop into read_data.
REQ-007 call  input  1  two-word push of ret_pc.
REQ-008 ret  input  1  two-word pop into pc_out.
REQ-009 rti  input  1  three-word pop: PC (2 words) then flags.
REQ-010 addr  input  16  ALU result; low ADDR_W bits used.
REQ-011 write_data  input  16  store/push data.
REQ-012 ret_pc  input  32  PC saved by call.
REQ-013 read_data  output  16  load/pop result, registered.
REQ-014 conditions_from_memory_pop  output  3  flags restored by rti, registered.
REQ-015 flag_regsel  output  1  one-cycle pulse; tells ALU flag register to take conditions_from_memory_pop.
REQ-016 pc_out  output  32  PC restored by ret/rti; pc_load  output  1  one-cycle pulse when pc_out valid.
REQ-017 stall  output  1  upstream must hold inputs stable while high.
REQ-018 sp  output  ADDR_W  current stack pointer.

Function
REQ-019 Memory: 2^ADDR_W x 16 array, synchronous write on posedge, not cleared by reset.
REQ-020 Request priority when several asserted in IDLE: rti > ret > call > pop > push > mem_write > mem_read; only the winner is executed.
REQ-021 Push: mem[sp] <= write_data, sp <= sp-1, 1 cycle, stall low.
REQ-022 Pop: sp <= sp+1, read_data <= mem[sp+1], 1 cycle, stall low.
REQ-023 Load: read_data <= mem[addr] at posedge of the request cycle; store: mem[addr] <= write_data; 1 cycle each.
REQ-024 sp arithmetic modulo 2^ADDR_W; wrap silently (0 - 1 -> all-ones, all-ones + 1 -> 0).
REQ-025 FSM states: IDLE, CALL_LO, RET_HI, RTI_HI, RTI_FL.
REQ-026 call: cycle 1 (IDLE) mem[sp] <= ret_pc[31:16], sp--, -> CALL_LO, stall high; cycle 2 mem[sp] <= ret_pc[15:0], sp--, -> IDLE, stall low.
REQ-027 ret: cycle 1 sp++, pc_out[15:0] <= mem[sp+1], -> RET_HI, stall high; cycle 2 sp++, pc_out[31:16] <= mem[sp+1], pc_load pulses next cycle, -> IDLE.
REQ-028 rti: cycles 1-2 as ret via RTI_HI; cycle 3 (RTI_FL) sp++, conditions_from_memory_pop <= mem[sp+1][2:0], -> IDLE; pc_load and flag_regsel pulse together the cycle after cycle 3; stall high in cycles 1-2.
REQ-029 stall is combinational from state: high in CALL_LO? no -- high exactly in the IDLE cycle launching call/ret/rti and in every non-final state; low in the final cycle of each operation.
REQ-030 All request inputs are ignored in non-IDLE states.
REQ-031 read_data, pc_out, conditions_from_memory_pop hold value until next overwrite.

Reset
REQ-032 On rst: state IDLE, sp all-ones (0x7FF at default), read_data 0, pc_out 0, conditions_from_memory_pop 0, pc_load 0, flag_regsel 0; memory retained.
REQ-033 rst mid call/ret/rti aborts operation immediately; partial stack writes stay in memory, no pc_load/flag_regsel pulse.

Verification
REQ-034 Reset, push 0x1234 then pop -> sp 0x7FE then 0x7FF, read_data 0x1234, stall never high.
REQ-035 call ret_pc 0xDEAD_BEEF then ret -> mem[0x7FF]=0xDEAD, mem[0x7FE]=0xBEEF, pc_out 0xDEADBEEF, pc_load one pulse, sp back to 0x7FF, stall high 1 cycle per op.
REQ-036 push 0x0005 (flags 101), call 0x0000_0040, rti -> pc_out 0x00000040, conditions_from_memory_pop 3'b101, flag_regsel and pc_load pulse same cycle, stall high 2 cycles.
REQ-037 sp=0 then push -> sp wraps to 0x7FF; pop at 0x7FF -> sp 0, reads mem[0].
REQ-038 push, pop, mem_write asserted together -> only pop executed; mem_write addr unchanged.
REQ-039 rst asserted in RET_HI -> state IDLE, sp 0x7FF, pc_load never pulses.
